// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle controller: FSM states,
// RV32 opcode values, ALU operation codes and ALUSrcB selections.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_I,
    ADDR,
    MEM_LD,
    MEM_SD,
    WB_ALU,
    WB_MEM,
    BRANCH,
    HALT
  } state_e;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [1:0] SRCB_RD2  = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  // States that hold an outstanding memory request.
  function automatic logic is_mem_state(input state_e s);
    return (s == FETCH) || (s == MEM_LD) || (s == MEM_SD);
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_op_decoder.sv
// ALU operation decode from {instr[30], funct3}; for I-type the instr[30]
// bit is an immediate bit, so it is masked and subtraction is unreachable.
module alu_op_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [3:0] funct_i,
  input  logic       is_rtype_i,
  output logic [3:0] operation_o
);

  logic [3:0] key;

  assign key = is_rtype_i ? funct_i : {1'b0, funct_i[2:0]};

  // NOTE: give every always_comb output a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    operation_o = ALU_ADD;
    case (key)
      4'b0000: operation_o = ALU_ADD;
      4'b1000: operation_o = ALU_SUB;
      4'b0111: operation_o = ALU_AND;
      4'b0110: operation_o = ALU_OR;
      default: operation_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32 subset control FSM with timed memory handshake.
// Optional MC_PERF_CNT_EN adds instret/cycles performance counters.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [3:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemToReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] Operation,
`ifdef MC_PERF_CNT_EN
  output logic [31:0] instret,
  output logic [31:0] cycles,
`endif
  output logic       error
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            state_q;
  logic [WAIT_W-1:0] wait_q;
  logic              run_q;
  logic              in_mem;
  logic              ready_ok;
  logic              timed_out;
  logic [3:0]        dec_op;

  // run_q keeps the reset-state FETCH quiet until the first clock edge, so a
  // mem_ready left over from an aborted access cannot complete the fetch.
  assign in_mem    = run_q && is_mem_state(state_q);
  assign ready_ok  = in_mem && mem_ready;
  assign timed_out = in_mem && !mem_ready && (wait_q == WAIT_LAST);

  alu_op_decoder u_alu_op_decoder (
    .funct_i     (funct),
    .is_rtype_i  (state_q == EXEC_R),
    .operation_o (dec_op)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      wait_q  <= '0;
      run_q   <= 1'b0;
    end else begin
      run_q  <= 1'b1;
      wait_q <= (in_mem && !mem_ready && !timed_out) ? wait_q + 1'b1 : '0;
      case (state_q)
        FETCH, MEM_LD, MEM_SD: begin
          if (timed_out) begin
            state_q <= HALT;
          end else if (ready_ok) begin
            case (state_q)
              FETCH:   state_q <= DECODE;
              MEM_LD:  state_q <= WB_MEM;
              default: state_q <= FETCH;
            endcase
          end
        end
        DECODE: begin
          case (opcode)
            OP_RTYPE:          state_q <= EXEC_R;
            OP_ITYPE:          state_q <= EXEC_I;
            OP_LOAD, OP_STORE: state_q <= ADDR;
            OP_BRANCH:         state_q <= BRANCH;
            default:           state_q <= HALT;
          endcase
        end
        EXEC_R, EXEC_I:          state_q <= WB_ALU;
        ADDR:                    state_q <= (opcode == OP_STORE) ? MEM_SD : MEM_LD;
        WB_ALU, WB_MEM, BRANCH:  state_q <= FETCH;
        default:                 state_q <= HALT;
      endcase
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IorD      = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemToReg  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_RD2;
    Operation = ALU_ADD;
    case (state_q)
      FETCH: begin
        mem_req = run_q;
        MemRead = run_q;
        ALUSrcB = run_q ? SRCB_FOUR : SRCB_RD2;
        IRWrite = ready_ok;
        PCWrite = ready_ok;
      end
      EXEC_R: begin
        ALUSrcA   = 1'b1;
        Operation = dec_op;
      end
      EXEC_I: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_IMM;
        Operation = dec_op;
      end
      WB_ALU: RegWrite = 1'b1;
      ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      MEM_LD: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      WB_MEM: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      MEM_SD: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      BRANCH: begin
        ALUSrcA   = 1'b1;
        Operation = ALU_SUB;
        PCWrite   = zero;
      end
      default: ;
    endcase
  end

  assign error = (state_q == HALT);

`ifdef MC_PERF_CNT_EN
  logic [31:0] instret_q;
  logic [31:0] cycles_q;
  logic        retire;

  assign retire = (state_q == WB_ALU) || (state_q == WB_MEM) || (state_q == BRANCH) ||
                  ((state_q == MEM_SD) && ready_ok);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instret_q <= '0;
      cycles_q  <= '0;
    end else begin
      if (retire) instret_q <= instret_q + 32'd1;
      if (state_q != HALT) cycles_q <= cycles_q + 32'd1;
    end
  end

  assign instret = instret_q;
  assign cycles  = cycles_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: directed scenarios plus random instruction mix against
// an instruction-level model (latency, pulse counts, ALU setup per class).
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [3:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, RegWrite, MemToReg, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] Operation;
  logic       error;
`ifdef MC_PERF_CNT_EN
  logic [31:0] instret, cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int req_k = 0;

  typedef enum int {K_R, K_I, K_LD, K_ST, K_BR} kind_e;

  multicycle_controller #(.MEM_TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .IorD      (IorD),
    .IRWrite   (IRWrite),
    .PCWrite   (PCWrite),
    .RegWrite  (RegWrite),
    .MemToReg  (MemToReg),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .Operation (Operation),
`ifdef MC_PERF_CNT_EN
    .instret   (instret),
    .cycles    (cycles),
`endif
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_alu(input logic [3:0] f);
    case (f)
      4'b0000: return 4'b0010;
      4'b1000: return 4'b0110;
      4'b0111: return 4'b0000;
      4'b0110: return 4'b0001;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic logic [6:0] opcode_of(input kind_e k);
    case (k)
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_LD:    return 7'b0000011;
      K_ST:    return 7'b0100011;
      default: return 7'b1100011;
    endcase
  endfunction

  // Memory model: answers a request after fw (fetch) or mw (data) extra
  // cycles; toggles mem_ready randomly when nothing is requested.
  task automatic step_cycle(input int fw, input int mw, output logic rdy);
    @(negedge clk);
    if (mem_req) begin
      rdy   = (req_k == (IorD ? mw : fw));
      req_k = rdy ? 0 : req_k + 1;
    end else begin
      rdy   = 1'($urandom_range(0, 1));
      req_k = 0;
    end
    mem_ready = rdy;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset     = 1'b0;
    mem_ready = 1'b0;
    req_k     = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Runs one instruction for exactly its architectural latency and checks
  // the observable effects against the instruction-class rules.
  task automatic run_instr(input kind_e k, input logic [3:0] f, input logic z,
                           input int fw, input int mw, input string tag,
                           output int total);
    int   n_rw, n_wbm, n_pcw, n_irw, n_mw, n_ld;
    logic rdy, in_req;
    logic [2:0] req_sig;
    logic [3:0] exp_op;
    logic [1:0] exp_srcb;
    opcode = opcode_of(k);
    funct  = f;
    zero   = z;
    case (k)
      K_R, K_I: total = 4 + fw;
      K_LD:     total = 5 + fw + mw;
      K_ST:     total = 4 + fw + mw;
      default:  total = 3 + fw;
    endcase
    case (k)
      K_R:     begin exp_op = ref_alu(f);                exp_srcb = 2'd0; end
      K_I:     begin exp_op = ref_alu({1'b0, f[2:0]});   exp_srcb = 2'd2; end
      K_BR:    begin exp_op = 4'b0110;                   exp_srcb = 2'd0; end
      default: begin exp_op = 4'b0010;                   exp_srcb = 2'd2; end
    endcase
    n_rw = 0; n_wbm = 0; n_pcw = 0; n_irw = 0; n_mw = 0; n_ld = 0;
    in_req = 1'b0; req_sig = '0;
    for (int c = 0; c < total; c++) begin
      step_cycle(fw, mw, rdy);
      if (c == 0) check({tag, "/fetch_start"}, {mem_req, MemRead, MemWrite, IorD}, 4'b1100);
      if (c == fw + 2) begin
        check({tag, "/alu_op"}, Operation, exp_op);
        check({tag, "/alu_srcb"}, ALUSrcB, exp_srcb);
        if (k != K_I) check({tag, "/alu_srca"}, ALUSrcA, 1'b1);
      end
      if (mem_req) begin
        if (in_req) check({tag, "/req_stable"}, {MemRead, MemWrite, IorD}, req_sig);
        req_sig = {MemRead, MemWrite, IorD};
        in_req  = !rdy;
      end else begin
        in_req = 1'b0;
      end
      n_rw  += int'(RegWrite);
      n_wbm += int'(RegWrite && MemToReg);
      n_pcw += int'(PCWrite);
      n_irw += int'(IRWrite);
      n_mw  += int'(mem_req && MemWrite);
      n_ld  += int'(mem_req && MemRead && IorD);
    end
    check({tag, "/regwrite_pulses"}, n_rw, (k == K_R || k == K_I || k == K_LD) ? 1 : 0);
    check({tag, "/wb_mem_pulses"}, n_wbm, (k == K_LD) ? 1 : 0);
    check({tag, "/pcwrite_pulses"}, n_pcw, 1 + ((k == K_BR && z) ? 1 : 0));
    check({tag, "/irwrite_pulses"}, n_irw, 1);
    check({tag, "/store_cycles"}, n_mw, (k == K_ST) ? mw + 1 : 0);
    check({tag, "/load_cycles"}, n_ld, (k == K_LD) ? mw + 1 : 0);
    check({tag, "/no_error"}, error, 1'b0);
  endtask

  initial begin
    logic rdy;
    int   t, s;
    reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    #1 reset = 1'b0;
    #1 check("rst_outputs", {mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, RegWrite, MemToReg, error}, 9'd0);
    repeat (2) @(posedge clk);
    #1 check("rst_hold_outputs", {mem_req, IRWrite, PCWrite, RegWrite, error}, 5'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 check("release_pre_edge_req", mem_req, 1'b0);
`ifdef MC_PERF_CNT_EN
    check("perf_rst_instret", instret, 32'd0);
    check("perf_rst_cycles", cycles, 32'd0);
`endif

    run_instr(K_R, 4'b0000, 1'b0, 1, 0, "r_add", t);
    run_instr(K_R, 4'b1000, 1'b1, 0, 0, "r_sub", t);
    run_instr(K_R, 4'b0111, 1'b0, 2, 0, "r_and", t);
    run_instr(K_R, 4'b0110, 1'b0, 0, 0, "r_or", t);
    run_instr(K_R, 4'b0101, 1'b0, 0, 0, "r_other", t);
    run_instr(K_I, 4'b1111, 1'b0, 0, 0, "i_and_bit30", t);
    run_instr(K_I, 4'b1000, 1'b0, 1, 0, "i_no_sub", t);
    run_instr(K_LD, 4'b0010, 1'b0, 0, 3, "ld_wait3", t);
    run_instr(K_ST, 4'b0010, 1'b0, 2, 1, "st_wait", t);
    run_instr(K_BR, 4'b0000, 1'b1, 0, 0, "beq_taken", t);
    run_instr(K_BR, 4'b0000, 1'b0, 1, 0, "beq_not_taken", t);
    run_instr(K_LD, 4'b0010, 1'b0, 15, 15, "ready_at_timeout_limit", t);

    // Illegal opcode: DECODE sends to HALT, which must stay silent.
    apply_reset();
    opcode = 7'b1111111;
    step_cycle(0, 0, rdy);
    step_cycle(0, 0, rdy);
    check("illegal_decode_no_req", {mem_req, error}, 2'b00);
    for (int c = 0; c < 20; c++) begin
      step_cycle(0, 0, rdy);
      check("illegal_halt", {mem_req, error, RegWrite, PCWrite, IRWrite}, 5'b01000);
    end
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check("halt_async_reset", {mem_req, error}, 2'b00);
    @(negedge clk);
    reset = 1'b1;

    // Fetch that never completes: exactly 16 request cycles, then HALT.
    opcode = 7'b0110011;
    for (int c = 0; c < 16; c++) begin
      step_cycle(1000, 0, rdy);
      check("fetch_wait_req", {mem_req, IorD, error}, 3'b100);
    end
    for (int c = 0; c < 20; c++) begin
      step_cycle(1000, 0, rdy);
      check("fetch_timeout_halt", {mem_req, error}, 2'b01);
    end

    // Reset in the middle of a store, with a stale mem_ready across release.
    apply_reset();
    opcode = 7'b0100011;
    for (int c = 0; c < 5; c++) step_cycle(0, 1000, rdy);
    check("mid_store_req", {mem_req, MemWrite, IorD}, 3'b111);
    mem_ready = 1'b1;
    #2 reset = 1'b0;
    #1 check("mid_store_reset", {mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, RegWrite, error}, 8'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    #1 check("post_reset_fetch", {mem_req, MemRead, IorD, IRWrite}, 4'b1100);
    @(negedge clk);
    #1 check("stale_ready_not_credited", {mem_req, MemRead, IorD}, 3'b110);

    // Three retired instructions from reset.
    apply_reset();
    s = 0;
    run_instr(K_R, 4'b0000, 1'b0, 0, 0, "perf_r", t);  s += t;
    run_instr(K_ST, 4'b0000, 1'b0, 1, 2, "perf_st", t); s += t;
    run_instr(K_BR, 4'b0000, 1'b0, 0, 0, "perf_br", t); s += t;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
`ifdef MC_PERF_CNT_EN
    check("perf_instret_3", instret, 32'd3);
    check("perf_cycles", cycles, s + 1);
`else
    check("perf_absent_next_fetch", {mem_req, IorD}, 2'b10);
`endif

    apply_reset();
    for (int i = 0; i < 40; i++) begin
      run_instr(kind_e'($urandom_range(0, 4)), 4'($urandom), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3), $sformatf("rand%0d", i), t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: maximum cycles to wait for mem_ready before flagging error.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port opcode  input  7  opcode field of the held instruction register.
REQ-005 SHALL have port funct  input  4  {instr[30], instr[14:12]}.
REQ-006 SHALL have port zero  input  1  ALU zero flag.
REQ-007 SHALL have port mem_ready  input  1  memory completion strobe for the current access.
REQ-008 SHALL have port mem_req  output  1  memory access request, held until mem_ready.
REQ-009 SHALL have ports MemRead and MemWrite  output  1 each  memory direction qualifiers, valid while mem_req=1.
REQ-010 SHALL have port IorD  output  1  memory address select: 0=PC, 1=ALU result.
REQ-011 SHALL have ports IRWrite, PCWrite, RegWrite, MemToReg  output  1 each  datapath enables/select.
REQ-012 SHALL have ports ALUSrcA  output  1 (0=PC, 1=ReadData1) and ALUSrcB  output  2 (0=ReadData2, 1=const 4, 2=imm_data).
REQ-013 SHALL have port Operation  output  4  ALU operation code.
REQ-014 SHALL have port error  output  1  sticky fault flag (illegal opcode or memory timeout).

Function
REQ-015 SHALL implement states FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_LD, MEM_SD, WB_ALU, WB_MEM, BRANCH, HALT.
REQ-016 FETCH: mem_req=1, MemRead=1, IorD=0; on mem_ready, IRWrite=1, PCWrite=1 (ALUSrcA=0, ALUSrcB=1, Operation=0010, PC+4), next DECODE; otherwise stay in FETCH.
REQ-017 DECODE: opcode 0110011 -> EXEC_R, 0010011 -> EXEC_I, 0000011 or 0100011 -> ADDR, 1100011 -> BRANCH; any other opcode -> HALT with error=1.
REQ-018 EXEC_R: ALUSrcA=1, ALUSrcB=0, Operation per funct: 0000->0010 add, 1000->0110 sub, 0111->0000 and, 0110->0001 or, others->0010; next WB_ALU.
REQ-019 EXEC_I: ALUSrcB=2, Operation decoded from funct[2:0] as in REQ-018, with funct[3] ignored; next WB_ALU.
REQ-020 WB_ALU: RegWrite=1, MemToReg=0; next FETCH.
REQ-021 ADDR: ALUSrcA=1, ALUSrcB=2, Operation=0010; next MEM_LD for a load, MEM_SD for a store.
REQ-022 MEM_LD: mem_req=1, MemRead=1, IorD=1; on mem_ready -> WB_MEM. WB_MEM: RegWrite=1, MemToReg=1; next FETCH.
REQ-023 MEM_SD: mem_req=1, MemWrite=1, IorD=1; on mem_ready -> FETCH.
REQ-024 BRANCH: ALUSrcA=1, ALUSrcB=0, Operation=0110; PCWrite=zero; next FETCH. The datapath supplies the branch target via its adder.
REQ-025 Memory handshake: mem_req, MemRead, MemWrite and IorD SHALL remain stable from request until the cycle mem_ready is sampled high. mem_ready while no request is pending SHALL be ignored.
REQ-026 A wait counter SHALL clear on entry to each memory state and increment each cycle without mem_ready. When it reaches MEM_TIMEOUT-1 with no mem_ready, the next state SHALL be HALT with error=1. mem_ready on that same cycle SHALL take priority.
REQ-027 HALT: all enables 0 and mem_req=0; remain until reset.
REQ-028 All outputs SHALL be decoded combinationally from the registered state (Moore), except PCWrite and IRWrite in FETCH and PCWrite in BRANCH (Mealy on mem_ready/zero).
REQ-029 Latency: R/I = 4 cycles plus fetch wait; load = 5 plus waits; store and branch = 4 and 3 plus waits.

Reset
REQ-030 Asserting reset (low) at any time, including mid-access, SHALL force state=FETCH, wait counter=0, error=0, and all enables and mem_req to 0 asynchronously.
REQ-031 After release, mem_req SHALL assert on the first clock edge (FETCH). A mem_ready from an aborted access SHALL NOT be credited.

Configuration
REQ-032 Macro MC_PERF_CNT_EN, when defined, SHALL add outputs instret[31:0] and cycles[31:0]. instret increments on each transition into FETCH from WB_ALU, WB_MEM, MEM_SD or BRANCH. cycles increments every cycle outside HALT. Both wrap modulo 2^32 and reset to 0.
REQ-033 Without MC_PERF_CNT_EN, these ports and counters SHALL be absent.

Structure
REQ-034 A shared package SHALL hold the state enum, the opcode constants, the ALU Operation codes (0000/0001/0010/0110) and the ALUSrcB encodings.
REQ-035 ALU operation decode SHALL be a sub-module, alu_op_decoder (funct, is_rtype -> Operation).

Verification
REQ-036 R add: opcode 0110011, funct 0000, mem_ready 1 cycle after each request -> Operation=0010 in EXEC_R, RegWrite pulse exactly 1 cycle in WB_ALU.
REQ-037 Load with mem_ready delayed 3 cycles -> MEM_LD held 4 cycles with IorD=1 stable; WB_MEM has MemToReg=1, RegWrite=1.
REQ-038 BEQ with zero=1 then zero=0 -> PCWrite=1 in BRANCH only in the first case; both return to FETCH.
REQ-039 Opcode 1111111 -> HALT and error=1; mem_req stays 0 for 20 cycles.
REQ-040 mem_ready never asserted in FETCH with MEM_TIMEOUT=16 -> HALT and error=1 after exactly 16 cycles in FETCH.
REQ-041 reset low mid MEM_SD -> immediate FETCH with outputs 0; with MC_PERF_CNT_EN, instret=0 and instret=3 after three retired instructions.
